uart_rx_oversampled: RTL and testbench
======================================

Name: uart_rx_oversampled

Overview:
- UART serial receiver (8N1 by default). It consumes the 16x-oversampling tick produced by the baud rate generator (`done` output, wired to `s_tick`).
- Synchronizes the asynchronous `rx` line, finds the start bit, and samples each bit at its midpoint.
- Delivers the parallel byte with a one-cycle valid pulse and a framing-error flag.
- Sits on the receive path, opposite the UART transmitter, and shares the same tick source.

Parameters:
- DBIT, 8, number of data bits per frame (5..8), LSB first.
- SB_TICK, 16, oversampling ticks spent in the stop phase (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- s_tick  input  1  oversampling enable, 16 pulses per bit period, one clk wide each.
- rx  input  1  asynchronous serial line, idle high.
- rx_dout  output  DBIT  last received data word.
- rx_done_tick  output  1  one-clk pulse when rx_dout is updated.
- frame_err  output  1  one-clk pulse, coincident with rx_done_tick, when the stop bit was sampled low.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high: it is evaluated only at a clk rising edge while reset=1.
- Reset values:
  - state=IDLE; s_cnt=0; n_cnt=0; shift register=0.
  - Both synchronizer flops=1 (line idle).
  - rx_dout=0, rx_done_tick=0, frame_err=0.
- rx input path:
  - rx passes through a 2-flop synchronizer; only the synchronized value rx_s is used.
  - Latency from an rx change to rx_s is 2 clk.
- Counters:
  - s_cnt is 6 bits and counts s_tick pulses within a bit.
  - n_cnt is clog2(DBIT) bits and counts data bits.
  - Counters and state change only in cycles with s_tick=1, except the IDLE exit.
  - Cycles with s_tick=0 hold all state.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when rx_s=0 (s_tick not required), go to START and clear s_cnt.
  - START: on s_tick with s_cnt=7 (midpoint of the start bit):
    - if rx_s=0, go to DATA and clear s_cnt and n_cnt;
    - if rx_s=1, treat it as a glitch and return to IDLE with no output pulse.
    - On other s_tick cycles, increment s_cnt.
  - DATA: on s_tick with s_cnt=15:
    - shift rx_s into the MSB of the shift register (right shift, so LSB-first order lands correctly); clear s_cnt;
    - if n_cnt=DBIT-1, go to STOP; otherwise increment n_cnt.
    - On other s_tick cycles, increment s_cnt.
  - STOP: on s_tick with s_cnt=SB_TICK-1:
    - capture shift register into rx_dout;
    - pulse rx_done_tick=1 for exactly one clk;
    - set frame_err = ~rx_s for that same clk;
    - return to IDLE.
    - On other s_tick cycles, increment s_cnt.
- Framing error: the data word is still delivered when frame_err=1.
- rx_dout holds its value until the next rx_done_tick.
- rx_done_tick and frame_err are registered outputs, low in every other cycle.
- Back-to-back frames: the STOP exit occurs at the middle of the stop bit. A start edge that follows immediately is detected from IDLE on the next cycle, so no idle gap is required.
- The rx line stuck low after a framing error yields repeated frames of 0 with frame_err=1. This is accepted behaviour.
- Reset mid-frame: abandon the frame immediately, with no pulse. The next falling edge after reset is released starts a fresh frame.
- No parity, no FIFO. Overrun is the consumer's responsibility: it must take rx_dout within one frame time.

Decomposition:
- Shared package `uart_pkg`:
  - rx FSM state enumeration (2 bits: IDLE=0, START=1, DATA=2, STOP=3);
  - constants OVERSAMPLE=16 and MID_SAMPLE=7 (both shared with the transmitter).
- One sub-module, `sync_2ff`: a two-flop synchronizer with a reset value parameter of 1, reusable for other asynchronous inputs.

Test Plan:
- Common setup: s_tick every 4 clk, so 64 clk per bit. Send 0x55 as 8N1 → exactly one rx_done_tick, rx_dout=0x55, frame_err=0, pulse near the middle of the stop bit.
- Send 0xA3 with the stop bit driven 0 → rx_dout=0xA3, frame_err=1 coincident with rx_done_tick, then FSM returns to IDLE.
- rx low for 2 ticks (8 clk) then high → FSM enters START and returns to IDLE; no rx_done_tick; rx_dout unchanged.
- Back-to-back 0x00 then 0xFF with no idle gap → two rx_done_tick pulses, 640 clk apart, values 0x00 and 0xFF, frame_err=0 both.
- Assert reset for 1 clk during data bit 3 → all outputs 0, FSM in IDLE. Then send 0x3C → rx_dout=0x3C with one pulse.
- Hold s_tick=0 for 100 clk mid-DATA, then resume → state frozen during the gap, byte 0x96 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART receiver and transmitter:
//                receiver FSM state encoding and oversampling constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Ticks per bit period delivered by the baud rate generator.
    localparam int OVERSAMPLE = 16;

    // Tick index (0-based) at the middle of the start bit.
    localparam int MID_SAMPLE = 7;

    // Receiver FSM state encoding.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_oversampled_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_oversampled_if
//  Description : Signal bundle between the UART receiver and its environment:
//                oversampling tick and serial line in, received word and
//                status pulses out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_oversampled_if #(
    parameter int DBIT = 8
) ();

    logic            s_tick;
    logic            rx;
    logic [DBIT-1:0] rx_dout;
    logic            rx_done_tick;
    logic            frame_err;

    // Receiver side.
    modport slave (
        input  s_tick,
        input  rx,
        output rx_dout,
        output rx_done_tick,
        output frame_err
    );

    // Side that owns the tick and the line and consumes the results.
    modport master (
        output s_tick,
        output rx,
        input  rx_dout,
        input  rx_done_tick,
        input  frame_err
    );

endinterface : uart_rx_oversampled_if
`default_nettype wire

// File: rtl/uart_rx_oversampled_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for a single asynchronous input.
//                Both flops load RESET_VAL in reset so that a line with a
//                known idle level reads as idle straight out of reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage resynchronisation into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_oversampled
//  Description : UART serial receiver driven by a 16x oversampling tick.
//                Finds the start bit, samples every data bit at its middle
//                (LSB first), checks the stop level and presents the word
//                with a one-clock done pulse and a coincident framing-error
//                pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    uart_rx_oversampled_if.slave bus
);

    // Bit counter width; at least one bit even for a single-bit word.
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic            w_rx_s;

    rx_state_t       r_state;
    rx_state_t       w_state_nx;

    logic [5:0]      r_s_cnt;
    logic [5:0]      w_s_cnt_nx;
    logic [NW-1:0]   r_n_cnt;
    logic [NW-1:0]   w_n_cnt_nx;
    logic [DBIT-1:0] r_shift;
    logic [DBIT-1:0] w_shift_nx;

    logic [DBIT-1:0] r_dout;
    logic [DBIT-1:0] w_dout_nx;
    logic            r_done;
    logic            w_done_nx;
    logic            r_ferr;
    logic            w_ferr_nx;

    logic            w_start_mid;
    logic            w_bit_end;
    logic            w_stop_end;
    logic            w_last_bit;

    // ------------------------------------------------------------------
    // Input synchronizer: the line idles high, so reset to 1 keeps the
    // receiver from seeing a false start edge when reset is released.
    // ------------------------------------------------------------------
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (reset),
        .i_d (bus.rx),
        .o_q (w_rx_s)
    );

    // ------------------------------------------------------------------
    // Sampling-point decodes; all of them are qualified by the tick.
    // ------------------------------------------------------------------
    assign w_start_mid = bus.s_tick && (r_s_cnt == 6'(MID_SAMPLE));
    assign w_bit_end   = bus.s_tick && (r_s_cnt == 6'(OVERSAMPLE - 1));
    assign w_stop_end  = bus.s_tick && (r_s_cnt == 6'(SB_TICK - 1));
    assign w_last_bit  = (r_n_cnt == NW'(DBIT - 1));

    // ------------------------------------------------------------------
    // FSM state register.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic: only the IDLE exit ignores the tick.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            RX_IDLE: begin
                if (!w_rx_s) begin
                    w_state_nx = RX_START;
                end
            end
            RX_START: begin
                // Line back high at the start-bit middle means a glitch.
                if (w_start_mid) begin
                    w_state_nx = w_rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_bit_end && w_last_bit) begin
                    w_state_nx = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_stop_end) begin
                    w_state_nx = RX_IDLE;
                end
            end
            default: begin
                w_state_nx = RX_IDLE;
            end
        endcase
    end

    // Output decode: the word is delivered at the stop sampling point
    // regardless of the stop level; the level only drives frame_err.
    always_comb begin
        w_done_nx = 1'b0;
        w_ferr_nx = 1'b0;
        w_dout_nx = r_dout;
        if ((r_state == RX_STOP) && w_stop_end) begin
            w_done_nx = 1'b1;
            w_ferr_nx = ~w_rx_s;
            w_dout_nx = r_shift;
        end
    end

    // ------------------------------------------------------------------
    // Datapath next values: tick counter, bit counter, shift register.
    // ------------------------------------------------------------------
    always_comb begin
        w_s_cnt_nx = r_s_cnt;
        w_n_cnt_nx = r_n_cnt;
        w_shift_nx = r_shift;
        case (r_state)
            RX_IDLE: begin
                if (!w_rx_s) begin
                    w_s_cnt_nx = 6'd0;
                end
            end
            RX_START: begin
                if (w_start_mid) begin
                    w_s_cnt_nx = 6'd0;
                    w_n_cnt_nx = '0;
                end else if (bus.s_tick) begin
                    w_s_cnt_nx = r_s_cnt + 6'd1;
                end
            end
            RX_DATA: begin
                if (w_bit_end) begin
                    // Right shift: the first (LSB) bit ends up in bit 0.
                    w_shift_nx = {w_rx_s, r_shift[DBIT-1:1]};
                    w_s_cnt_nx = 6'd0;
                    if (!w_last_bit) begin
                        w_n_cnt_nx = r_n_cnt + NW'(1);
                    end
                end else if (bus.s_tick) begin
                    w_s_cnt_nx = r_s_cnt + 6'd1;
                end
            end
            RX_STOP: begin
                if (bus.s_tick && !w_stop_end) begin
                    w_s_cnt_nx = r_s_cnt + 6'd1;
                end
            end
            default: begin
                w_s_cnt_nx = 6'd0;
            end
        endcase
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_cnt <= 6'd0;
            r_n_cnt <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_s_cnt <= w_s_cnt_nx;
            r_n_cnt <= w_n_cnt_nx;
            r_shift <= w_shift_nx;
            r_dout  <= w_dout_nx;
            r_done  <= w_done_nx;
            r_ferr  <= w_ferr_nx;
        end
    end

    assign bus.rx_dout      = r_dout;
    assign bus.rx_done_tick = r_done;
    assign bus.frame_err    = r_ferr;

endmodule : uart_rx_oversampled
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_oversampled
//  Description : Self-checking bench for uart_rx_oversampled. Frames are
//                timed in tick units (16 ticks per bit, tick every 4 clk),
//                expected words and pulse times come from the frame contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_oversampled;

    typedef struct {
        logic [7:0] d;
        logic       fe;
        int         cyc;
    } ev_t;

    logic clk;
    logic reset;
    logic tick_en;
    int   phase;
    int   cyc;
    int   checks;
    int   errors;
    int   stray;
    logic prev_done;

    ev_t  act_q[$];
    ev_t  exp_q[$];

    uart_rx_oversampled_if #(.DBIT(8)) bus ();

    uart_rx_oversampled #(
        .DBIT    (8),
        .SB_TICK (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time-stamp pulses.
    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Tick source: one pulse every 4 clk while enabled; phase freezes when off.
    initial begin
        bus.s_tick = 1'b0;
        phase      = 0;
        forever begin
            @(negedge clk);
            if (tick_en) begin
                phase      = (phase == 3) ? 0 : phase + 1;
                bus.s_tick = (phase == 0);
            end else begin
                bus.s_tick = 1'b0;
            end
        end
    end

    // Output monitor: records every done pulse, flags stray or long pulses.
    initial begin
        ev_t e;
        stray     = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rx_done_tick === 1'b1) begin
                e.d   = bus.rx_dout;
                e.fe  = bus.frame_err;
                e.cyc = cyc;
                act_q.push_back(e);
                if (prev_done === 1'b1) stray = stray + 1;
            end else if (bus.frame_err !== 1'b0 || bus.rx_done_tick !== 1'b0) begin
                stray = stray + 1;
            end
            prev_done = bus.rx_done_tick;
        end
    end

    // Safety net against a hung run.
    initial begin
        #3000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        assert (obs === expv) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Wait until n ticks have been sampled at rising edges; ends on a tick edge.
    task automatic wait_ticks(input int n);
        int k;
        k = 0;
        while (k < n) begin
            @(posedge clk);
            if (bus.s_tick === 1'b1) k = k + 1;
        end
    endtask

    // Drive one 8N1 frame. A low stop bit is held for 12 ticks so the line is
    // high again before any false start bit could be sampled. abort_bit >= 0
    // pulses reset in the middle of that frame bit and abandons the frame.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int gap,
                              input int abort_bit, input int extra);
        logic [9:0] fr;
        ev_t        e;
        fr    = {stop, d, 1'b0};
        e.cyc = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.rx = fr[i];
            if (i == 0) e.cyc = cyc + extra;
            if (i == abort_bit) begin
                wait_ticks(8);
                @(negedge clk);
                reset  = 1'b1;
                bus.rx = 1'b1;
                @(negedge clk);
                reset  = 1'b0;
                return;
            end
            if (i == 9 && !stop) begin
                wait_ticks(12);
                @(negedge clk);
                bus.rx = 1'b1;
                wait_ticks(4);
            end else begin
                wait_ticks(16);
            end
        end
        e.d  = d;
        e.fe = ~stop;
        exp_q.push_back(e);
        if (gap > 0) begin
            @(negedge clk);
            bus.rx = 1'b1;
            wait_ticks(gap);
        end
    endtask

    // Compare recorded pulses with expected frames; the pulse must land near
    // the middle of the stop bit (9.5 bit periods = 608 clk after start).
    task automatic check_frames(input string tag);
        int n;
        int diff;
        chk({tag, "_count"}, act_q.size(), exp_q.size());
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_data"}, 32'(act_q[i].d), 32'(exp_q[i].d));
            chk({tag, "_ferr"}, 32'(act_q[i].fe), 32'(exp_q[i].fe));
            diff   = act_q[i].cyc - exp_q[i].cyc;
            checks = checks + 1;
            assert (diff >= 604 && diff <= 612) else begin
                errors = errors + 1;
                $error("FAIL %s_time observed=%0d expected=604..612", tag, diff);
            end
        end
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] rd;
        logic       rs;
        int         rg;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        tick_en = 1'b1;
        bus.rx  = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        chk("reset_dout", 32'(bus.rx_dout), 32'h0);
        chk("reset_done", 32'(bus.rx_done_tick), 32'h0);
        chk("reset_ferr", 32'(bus.frame_err), 32'h0);
        wait_ticks(4);

        // Clean frame.
        send_frame(8'h55, 1'b1, 8, -1, 0);
        check_frames("f55");

        // Stop bit low: word delivered with frame_err.
        send_frame(8'hA3, 1'b0, 8, -1, 0);
        check_frames("fA3");

        // Start glitch of 2 ticks: no pulse, word unchanged.
        @(negedge clk);
        bus.rx = 1'b0;
        wait_ticks(2);
        @(negedge clk);
        bus.rx = 1'b1;
        wait_ticks(200);
        check_frames("glitch");
        chk("glitch_dout", 32'(bus.rx_dout), 32'hA3);

        // Back-to-back frames, no idle gap.
        send_frame(8'h00, 1'b1, 0, -1, 0);
        send_frame(8'hFF, 1'b1, 8, -1, 0);
        if (act_q.size() >= 2) chk("b2b_spacing", act_q[1].cyc - act_q[0].cyc, 640);
        check_frames("b2b");

        // Reset during data bit 3 abandons the frame.
        send_frame(8'hC5, 1'b1, 0, 4, 0);
        chk("midrst_dout", 32'(bus.rx_dout), 32'h0);
        chk("midrst_done", 32'(bus.rx_done_tick), 32'h0);
        chk("midrst_ferr", 32'(bus.frame_err), 32'h0);
        wait_ticks(100);
        check_frames("midrst");
        send_frame(8'h3C, 1'b1, 8, -1, 0);
        check_frames("f3C");

        // Tick pause of 100 clk during data bit 2.
        fork
            send_frame(8'h96, 1'b1, 8, -1, 100);
            begin
                wait_ticks(48);
                tick_en = 1'b0;
                repeat (100) @(posedge clk);
                tick_en = 1'b1;
            end
        join
        check_frames("pause");

        // Random frames, mostly good stop bits, short random gaps.
        for (int n = 0; n < 10; n++) begin
            rd = 8'($urandom_range(0, 255));
            rs = ($urandom_range(0, 3) != 0);
            rg = $urandom_range(0, 6);
            send_frame(rd, rs, rg, -1, 0);
        end
        wait_ticks(8);
        check_frames("rand");

        chk("stray_pulses", stray, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_oversampled
`default_nettype wire
